// File: rtl/fade_pkg.sv
// Shared types and helpers for the fade engine: ramp modes and the per-channel
// phase offset used at reset and on restart.
package fade_pkg;

  typedef enum logic [1:0] {
    TRIANGLE = 2'd0,
    SAWTOOTH = 2'd1,
    HOLD     = 2'd2
  } mode_e;

  // Channels are spread evenly over the full 2*steps phase circle.
  function automatic int unsigned phase_offset(input int unsigned k,
                                               input int unsigned steps,
                                               input int unsigned channels);
    return k * ((2 * steps) / channels);
  endfunction

endpackage

// File: rtl/fade_tick_gen.sv
// Programmable tick divider: one tick every div+1 enabled cycles, restartable
// through clear. The >= compare keeps it live when div drops below the count.
module fade_tick_gen
  import fade_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count_q;
  logic [DIV_WIDTH-1:0] count_d;

  always_comb begin
    tick    = enable && !clear && (count_q >= div);
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fade_engine.sv
// Multi-channel brightness fader: phase-offset channels ramp in triangle or
// sawtooth shape on divided ticks, with hold, restart and a channel-0 wrap pulse.
module fade_engine
  import fade_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 16,
  parameter int STEPS     = 1024,
  parameter int DIV_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      restart,
  input  logic [1:0]                mode,
  input  logic [DIV_WIDTH-1:0]      div,
  output logic [CHANNELS*WIDTH-1:0] brightness,
  output logic                      wrap
);

  localparam int PW = $clog2(STEPS) + 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(2 * STEPS - 1);

  function automatic logic [WIDTH-1:0] tri_map(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    // 2*STEPS is 2**PW, so the mirrored half is simply the PW-bit negation.
    if (p <= PW'(STEPS)) begin
      r = p;
    end else begin
      r = PW'(~p + PW'(1));
    end
    return WIDTH'(r);
  endfunction

  function automatic logic [WIDTH-1:0] saw_map(input logic [PW-1:0] p);
    return WIDTH'({1'b0, p[PW-2:0]});
  endfunction

  // HOLD only freezes updates; any recompute while holding uses triangle shape.
  function automatic logic [WIDTH-1:0] map_phase(input logic [PW-1:0] p, input mode_e m);
    return (m == SAWTOOTH) ? saw_map(p) : tri_map(p);
  endfunction

  mode_e         mode_in;
  mode_e         mode_q;
  mode_e         mode_d;
  logic          tick;
  logic          advance;
  logic          wrap_q;
  logic          wrap_d;
  logic [PW-1:0] phase0;

  fade_tick_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .clear (restart),
    .div   (div),
    .tick  (tick)
  );

  always_comb begin
    mode_in = (mode == 2'd3) ? HOLD : mode_e'(mode);
    advance = tick && (mode_in != HOLD);
    mode_d  = mode_q;
    if (tick) begin
      mode_d = mode_in;
    end
    wrap_d = advance && (phase0 == PHASE_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= TRIANGLE;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam logic [PW-1:0] OFFSET = PW'(phase_offset(k, STEPS, CHANNELS));

    logic [PW-1:0]    phase_q;
    logic [PW-1:0]    phase_d;
    logic [WIDTH-1:0] bright_q;
    logic [WIDTH-1:0] bright_d;

    // Brightness is mapped from the next phase so it never lags the phase register.
    always_comb begin
      phase_d  = phase_q;
      bright_d = bright_q;
      if (restart) begin
        phase_d  = OFFSET;
        bright_d = map_phase(OFFSET, mode_q);
      end else if (advance) begin
        phase_d  = phase_q + PW'(1);
        bright_d = map_phase(phase_d, mode_in);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        phase_q  <= OFFSET;
        bright_q <= tri_map(OFFSET);
      end else begin
        phase_q  <= phase_d;
        bright_q <= bright_d;
      end
    end

    assign brightness[k*WIDTH +: WIDTH] = bright_q;

    if (k == 0) begin : g_phase0
      assign phase0 = phase_q;
    end
  end

endmodule

// File: tb/tb_fade_engine.sv
// Directed bench for fade_engine (4 channels, 8 steps, 8-bit outputs) with a
// cycle-level reference model and hand-computed spot checks.
module tb_fade_engine;

  localparam int CH = 4;
  localparam int ST = 8;
  localparam int W  = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            restart;
  logic [1:0]      mode;
  logic [DW-1:0]   div;
  logic [CH*W-1:0] brightness;
  logic            wrap;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  int m_ph[CH];
  int m_br[CH];
  int m_cnt;
  int m_mode;
  bit m_wrap;

  fade_engine #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .STEPS    (ST),
    .DIV_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .restart   (restart),
    .mode      (mode),
    .div       (div),
    .brightness(brightness),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  function automatic int b(input int k);
    return int'(brightness[k*W +: W]);
  endfunction

  function automatic int tri_of(input int p);
    return (p <= ST) ? p : 2 * ST - p;
  endfunction

  function automatic int shape(input int p, input int md);
    return (md == 1) ? (p % ST) : tri_of(p);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk4(input string nm, input int e0, input int e1, input int e2, input int e3);
    chk({nm, "_ch0"}, b(0), e0);
    chk({nm, "_ch1"}, b(1), e1);
    chk({nm, "_ch2"}, b(2), e2);
    chk({nm, "_ch3"}, b(3), e3);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the ramp rules stated as plain integer arithmetic.
  always @(posedge clk) begin
    int nm;
    if (reset) begin
      m_cnt  = 0;
      m_mode = 0;
      m_wrap = 1'b0;
      for (int k = 0; k < CH; k++) begin
        m_ph[k] = k * (2 * ST / CH);
        m_br[k] = tri_of(m_ph[k]);
      end
    end else begin
      m_wrap = 1'b0;
      if (restart) begin
        m_cnt = 0;
        for (int k = 0; k < CH; k++) begin
          m_ph[k] = k * (2 * ST / CH);
          m_br[k] = shape(m_ph[k], m_mode);
        end
      end else if (enable) begin
        if (m_cnt >= int'(div)) begin
          m_cnt  = 0;
          nm     = (mode == 2'd3) ? 2 : int'(mode);
          m_mode = nm;
          if (nm != 2) begin
            if (m_ph[0] == 2 * ST - 1) m_wrap = 1'b1;
            for (int k = 0; k < CH; k++) begin
              m_ph[k] = (m_ph[k] + 1) % (2 * ST);
              m_br[k] = shape(m_ph[k], nm);
            end
          end
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < CH; k++) chk($sformatf("model_ch%0d", k), b(k), m_br[k]);
      chk("model_wrap", int'(wrap), int'(m_wrap));
    end
  end

  initial begin
    int tri_exp[16] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    int saw_exp[16] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 0};
    int div2_exp[6] = '{1, 1, 2, 2, 2, 3};

    reset = 1'b1; enable = 1'b0; restart = 1'b0; mode = 2'd0; div = '0;
    cyc(); cyc();
    chk_en = 1'b1;
    chk4("reset", 0, 4, 8, 4);
    chk("reset_wrap", int'(wrap), 0);
    reset = 1'b0;
    cyc();
    chk4("idle", 0, 4, 8, 4);

    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("tri_ch0", b(0), tri_exp[i]);
      chk("tri_wrap", int'(wrap), (i == 15) ? 1 : 0);
    end
    cyc();
    chk("tri_after_ch0", b(0), 1);
    chk("tri_after_wrap", int'(wrap), 0);

    div = 8'd2;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("div2_ch0", b(0), div2_exp[i]);
    end
    div = 8'd5;
    repeat (3) begin
      cyc();
      chk("div5_ch0", b(0), 3);
    end
    div = 8'd1;
    cyc(); chk("div_drop_ch0", b(0), 4);
    cyc(); chk("div1_wait_ch0", b(0), 4);
    cyc(); chk("div1_tick_ch0", b(0), 5);

    div = 8'd0; restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk4("restart", 0, 4, 8, 4);
    chk("restart_wrap", int'(wrap), 0);
    cyc();
    chk4("post_restart", 1, 5, 7, 3);

    reset = 1'b1;
    cyc();
    reset = 1'b0; mode = 2'd1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("saw_ch0", b(0), saw_exp[i]);
      chk("saw_ch2", b(2), saw_exp[i]);
      for (int k = 0; k < CH; k++) chk("saw_below_steps", int'(b(k) < ST), 1);
    end
    chk("saw_wrap", int'(wrap), 1);

    mode = 2'd2;
    cyc();
    chk4("hold_enter", 0, 4, 0, 4);
    repeat (20) cyc();
    chk4("hold_20", 0, 4, 0, 4);
    chk("hold_wrap", int'(wrap), 0);

    enable = 1'b0; mode = 2'd0;
    repeat (20) cyc();
    chk4("disabled_20", 0, 4, 0, 4);
    enable = 1'b1;
    cyc();
    chk4("resume_tri", 1, 5, 7, 3);

    reset = 1'b1; restart = 1'b1; mode = 2'd3;
    cyc();
    reset = 1'b0; restart = 1'b0;
    chk4("reset_override", 0, 4, 8, 4);
    cyc();
    chk4("mode3_hold", 0, 4, 8, 4);
    cyc();
    chk4("mode3_hold2", 0, 4, 8, 4);

    mode = 2'd1;
    repeat (3) cyc();
    chk4("saw3", 3, 7, 3, 7);
    enable = 1'b0; restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk4("restart_saw_disabled", 0, 4, 0, 4);

    enable = 1'b1; mode = 2'd2;
    cyc();
    chk4("hold_latched", 0, 4, 0, 4);
    enable = 1'b0; restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk4("restart_hold_tri", 0, 4, 8, 4);
    chk("restart_hold_wrap", int'(wrap), 0);

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
